div_mod_unit: RTL

Parametrised iterative integer divider for the MIPS datapath. It produces quotient and remainder together, signed or unsigned, through a start/busy/write-enable handshake. It replaces the single-purpose modulo control unit and its external subtractor. It owns its own shift-subtract datapath, resolves one quotient bit per cycle, and pulses `We` so that `Quotient` and `Remainder` can go straight into the HI/LO register pair.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_mod_unit_step.sv | 24 ++
 rtl/div_mod_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
package div_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Quotient reported for a zero divisor (callers truncate to their width).
  localparam logic [MAX_W-1:0] DIV0_QUOTIENT = '1;

  // Two's-complement magnitude of a sign-extended operand.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v);
    return v[MAX_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/div_mod_unit_step.sv
// One restoring-division step: shift {rem, quo} left and trial-subtract.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // rem < divisor on entry, so WIDTH+1 bits hold both the shifted remainder
  // and the signed trial difference without overflow.
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    trial    = rem_sh - {1'b0, divisor};
    rem_next = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/div_mod_unit.sv
// Iterative signed/unsigned divider producing quotient and remainder.
module div_mod_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Signed_Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             We,
  output logic             Busy,
  output logic             Div_Zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             sgn_q, sgn_d;
  logic             bz_q, bz_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             we_q, we_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_rem, step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Operand magnitudes, computed on sign-extended copies of A and B.
  always_comb begin
    abs_a = WIDTH'(abs_val(MAX_W'(signed'(A))));
    abs_b = WIDTH'(abs_val(MAX_W'(signed'(B))));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    neg_a_d     = neg_a_q;
    neg_b_d     = neg_b_q;
    sgn_d       = sgn_q;
    bz_d        = bz_q;
    div_d       = div_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    we_d        = 1'b0;
    div_zero_d  = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (En) begin
          sgn_d   = Signed_Op;
          neg_a_d = Signed_Op & A[WIDTH-1];
          neg_b_d = Signed_Op & B[WIDTH-1];
          bz_d    = (B == '0);
          div_d   = Signed_Op ? abs_b : B;
          // With a zero divisor the quotient register carries raw A through
          // to FIX, where it becomes the reported remainder.
          quo_d   = (Signed_Op && (B != '0)) ? abs_a : A;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (B == '0) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        we_d    = 1'b1;
        state_d = S_DONE;
        if (bz_q) begin
          quotient_d  = WIDTH'(DIV0_QUOTIENT);
          remainder_d = quo_q;
          div_zero_d  = 1'b1;
        end else begin
          quotient_d  = (sgn_q && (neg_a_q ^ neg_b_q)) ? -quo_q : quo_q;
          remainder_d = (sgn_q && neg_a_q) ? -rem_q : rem_q;
          div_zero_d  = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      sgn_q       <= 1'b0;
      bz_q        <= 1'b0;
      div_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      we_q        <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      neg_a_q     <= neg_a_d;
      neg_b_q     <= neg_b_d;
      sgn_q       <= sgn_d;
      bz_q        <= bz_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      we_q        <= we_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign Quotient  = quotient_q;
  assign Remainder = remainder_q;
  assign We        = we_q;
  assign Div_Zero  = div_zero_q;
  assign Busy      = (state_q != S_IDLE);

endmodule
